// File: rtl/stream_merge.sv
// Two-source valid/ready merge into one tagged stream through a single output register.
// Define STREAM_MERGE_ROUND_ROBIN_EN for alternating arbitration; otherwise A has fixed priority.
module stream_merge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic load_en;
  logic last_sel;
  logic prefer_a;
  logic grant_a;
  logic grant_b;
  logic accept;

  assign load_en = !out_valid || out_ready;

`ifdef STREAM_MERGE_ROUND_ROBIN_EN
  // The source that did not win last time wins a contended cycle.
  assign prefer_a = last_sel;
`else
  // last_sel is still tracked, but the OR pins A as the contended winner.
  assign prefer_a = 1'b1 | last_sel;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = prefer_a;
      grant_b = !prefer_a;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // Readies are forced low while reset is held, independent of the clock.
  assign a_ready = rst_n && load_en && grant_a;
  assign b_ready = rst_n && load_en && grant_b;
  assign accept  = a_ready || b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      last_sel  <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= a_ready ? a_data : b_data;
      out_sel   <= b_ready;
      last_sel  <= b_ready;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
